// File: rtl/j1_fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues single-outstanding bus reads and queues returned words.
// Define J1_FETCH_ERR_EN to add ins_err_i/fet_err_o and an error tag on each queue entry.
module j1_fetch_queue #(
    parameter int AW        = 15,
    parameter int DW        = 16,
    parameter int DEPTH     = 4,
    parameter int RESET_ADR = 0
) (
    input  logic          sys_clk_i,
    input  logic          sys_res_i,
    output logic [AW-1:0] ins_adr_o,
    input  logic [DW-1:0] ins_dat_i,
    output logic          ins_cyc_o,
    output logic          ins_stb_o,
    input  logic          ins_ack_i,
`ifdef J1_FETCH_ERR_EN
    input  logic          ins_err_i,
    output logic          fet_err_o,
`endif
    output logic [DW-1:0] fet_dat_o,
    output logic [AW-1:0] fet_adr_o,
    output logic          fet_vld_o,
    input  logic          fet_rdy_i,
    input  logic          jmp_i,
    input  logic [AW-1:0] jmp_adr_i
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
`ifdef J1_FETCH_ERR_EN
    localparam int EW = AW + DW + 1;
`else
    localparam int EW = AW + DW;
`endif
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DISCARD
    } state_t;

    state_t        r_state;
    logic [AW-1:0] r_adr;
    logic [AW-1:0] r_tgt;
    logic [EW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;

    logic          w_term;
    logic          w_push;
    logic          w_pop;
    logic [CW-1:0] w_cntNext;
    logic [EW-1:0] w_entry;
    logic [EW-1:0] w_head;

`ifdef J1_FETCH_ERR_EN
    // An error terminates the cycle like an ack but stores zero data with the tag set.
    assign w_term  = ins_ack_i | ins_err_i;
    assign w_entry = {ins_err_i, r_adr, (ins_err_i ? {DW{1'b0}} : ins_dat_i)};
    assign fet_err_o = w_head[EW-1];
`else
    assign w_term  = ins_ack_i;
    assign w_entry = {r_adr, ins_dat_i};
`endif

    assign w_pop     = fet_vld_o & fet_rdy_i & ~jmp_i;
    assign w_push    = (r_state == S_FETCH) & w_term & ~jmp_i;
    assign w_cntNext = r_count + CW'(w_push) - CW'(w_pop);

    assign ins_adr_o = r_adr;
    assign ins_cyc_o = (r_state != S_IDLE);
    assign ins_stb_o = ins_cyc_o;

    assign w_head    = r_mem[r_rptr];
    assign fet_vld_o = (r_count != '0);
    assign fet_adr_o = w_head[AW+DW-1:DW];
    assign fet_dat_o = w_head[DW-1:0];

    always_ff @(posedge sys_clk_i or posedge sys_res_i) begin
        if (sys_res_i) begin
            r_state <= S_IDLE;
            r_adr   <= AW'(RESET_ADR);
            r_tgt   <= AW'(RESET_ADR);
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (jmp_i) begin
                        r_adr   <= jmp_adr_i;
                        r_state <= S_FETCH;
                    end else if (r_count < FULL) begin
                        r_state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (jmp_i) begin
                        if (w_term) begin
                            r_adr <= jmp_adr_i;
                        end else begin
                            r_tgt   <= jmp_adr_i;
                            r_state <= S_DISCARD;
                        end
                    end else if (w_term) begin
                        r_adr <= r_adr + AW'(1);
                        if (w_cntNext >= FULL) begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_DISCARD: begin
                    // Only the one in-flight response is dropped; a later jump just replaces the target.
                    if (jmp_i) begin
                        if (w_term) begin
                            r_adr   <= jmp_adr_i;
                            r_state <= S_FETCH;
                        end else begin
                            r_tgt <= jmp_adr_i;
                        end
                    end else if (w_term) begin
                        r_adr   <= r_tgt;
                        r_state <= S_FETCH;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge sys_clk_i or posedge sys_res_i) begin
        if (sys_res_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (jmp_i) begin
            r_rptr  <= r_wptr;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            r_count <= w_cntNext;
        end
    end

    always_ff @(posedge sys_clk_i) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_entry;
        end
    end

endmodule

// File: doc/j1_fetch_queue.md
Name: j1_fetch_queue

Overview:
- Parametrised instruction-fetch front end for the J1-class core; the next generation of the single-word, ack-stalled fetch.
- Owns the program counter for fetch and issues single-outstanding instruction reads on the instruction bus.
- Buffers returned words in a DEPTH-entry queue and presents them to the decoder over a valid/ready handshake.
- Supports jump redirect with queue flush and discard of an in-flight response.

Parameters:
- AW, 15: word-address width of ins_adr_o, jmp_adr_i and fet_adr_o.
- DW, 16: instruction word width.
- DEPTH, 4: queue entries; power of two, minimum 2.
- RESET_ADR, 0: fetch address loaded on reset.

Ports:
- sys_clk_i  in  1  system clock; all state changes on the rising edge.
- sys_res_i  in  1  asynchronous, active-high reset.
- ins_adr_o  out  AW  word address of the current bus read.
- ins_dat_i  in  DW  read data; sampled when ins_ack_i=1.
- ins_cyc_o  out  1  bus cycle in progress.
- ins_stb_o  out  1  transfer strobe; always equal to ins_cyc_o.
- ins_ack_i  in  1  transfer acknowledge.
- fet_dat_o  out  DW  instruction at queue head.
- fet_adr_o  out  AW  address of the instruction at queue head.
- fet_vld_o  out  1  queue head valid (queue not empty).
- fet_rdy_i  in  1  decoder consumes the head when fet_vld_o=1.
- jmp_i  in  1  redirect request.
- jmp_adr_i  in  AW  redirect target.

Behaviour:
- Reset, asynchronous: ins_adr_o=RESET_ADR; ins_cyc_o=ins_stb_o=0; queue empty; fet_vld_o=0; discard flag=0.
- On the first rising edge after reset release, ins_cyc_o/ins_stb_o rise with ins_adr_o=RESET_ADR.
- Bus rules:
  - At most one read is outstanding.
  - While the cycle is unacknowledged, ins_adr_o, ins_cyc_o and ins_stb_o are held stable for any number of cycles.
- Ack edge, not discarding:
  - Write {ins_adr_o, ins_dat_i} to the queue tail.
  - ins_adr_o <= ins_adr_o+1, modulo 2^AW (all ones wraps to 0).
- Strobe after an ack: stays asserted on the next cycle if (count + 1 - pop) < DEPTH.
  - With ins_ack_i held high and the decoder consuming, one word is fetched per clock.
- Full: count==DEPTH means no cycle is active. Strobe reasserts on the edge after a pop makes count<DEPTH.
- Pop: fet_vld_o & fet_rdy_i pops the head. A pop and a write in the same cycle leave count unchanged.
- Queue latency: a word acked at edge N is visible on fet_dat_o/fet_adr_o after edge N when the queue was empty (combinational head read from registered storage).
- Redirect (jmp_i=1 at an edge):
  - Queue is flushed: count=0 and fet_vld_o=0 after the edge. fet_rdy_i is ignored that cycle.
  - No cycle active: ins_adr_o <= jmp_adr_i and the cycle starts on that edge.
  - Cycle active, ins_ack_i=0: discard flag is set and the target is latched. Bus signals stay unchanged until ack. The acked data is dropped, and on that ack edge ins_adr_o <= latched target with strobe held.
  - Cycle active, ins_ack_i=1 on the same edge: ack data is dropped and ins_adr_o <= jmp_adr_i, strobe held.
  - Further jmp_i while discarding: the latest target wins, and only one response is dropped.
- jmp_i asserted during reset is ignored.
- Reset asserted mid-cycle: all outputs drop immediately to their reset values. A late ack is ignored.
- Internal state machine: IDLE (no cycle), FETCH (cycle active), DISCARD (cycle active, response to drop).
  - IDLE->FETCH when count<DEPTH or jmp_i.
  - FETCH->IDLE on ack with the queue becoming full.
  - FETCH->DISCARD on jmp_i without ack.
  - DISCARD->FETCH on ack.

Optional Feature:
- Macro: J1_FETCH_ERR_EN.
- Enabled:
  - Adds input ins_err_i (1) and output fet_err_o (1).
  - ins_err_i terminates a cycle exactly like ins_ack_i.
  - The entry is written with error tag 1 and ins_dat_i is ignored (data stored as 0).
  - fet_err_o is the head entry's tag.
  - After an error, ins_adr_o still increments and fetching continues.
  - A simultaneous ack and err is treated as err.
  - In DISCARD, err is dropped like ack.
- Disabled: neither port exists, and the queue stores no tag bit.

Test Plan:
- Reset stall: release reset, ins_ack_i=0 for 4 cycles -> ins_adr_o=0, ins_cyc_o=ins_stb_o=1 throughout, fet_vld_o=0.
- Single ack: pulse ins_ack_i one cycle with ins_dat_i=16'hA5A5 -> ins_adr_o=1; fet_vld_o=1, fet_dat_o=A5A5, fet_adr_o=0.
- Streaming: ins_ack_i and fet_rdy_i held high -> ins_adr_o steps 1,2,3 on consecutive edges; fet_adr_o follows 0,1,2.
- Fill: fet_rdy_i=0, ins_ack_i=1 -> after 4 acks ins_cyc_o=0 and ins_adr_o=4; one pop -> ins_cyc_o=1 on the next edge.
- In-flight redirect: cycle at adr 7 unacked, jmp_i=1 with jmp_adr_i=15'h0100, ack 2 cycles later -> queue empty, adr-7 data never presented, ins_adr_o=0x100, first fet_adr_o=0x100.
- Wrap: jump to 15'h7FFF, ack twice -> fet_adr_o sequence 7FFF then 0000.
